alu_exec_stage: RTL and testbench

//  Execute stage directly downstream of the 2-read/1-write register file. Consumes
//  two operands read from the file plus an opcode and destination address, computes
//  a result and drives the register file write port (write_addr/data/write_en).

---
 rtl/alu_exec_stage.sv | 144 ++++++++++++++
 tb/tb_alu_exec_stage.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// Execute stage feeding the register-file write port: single-cycle ALU ops plus
// an iterative LSB-first shift-add multiplier, with a one-entry valid/ready output hold.
module alu_exec_stage #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [WIDTH-1:0]  opa,
  input  logic [WIDTH-1:0]  opb,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [WIDTH-1:0]  wb_data,
  output logic              wb_en,
  output logic              illegal_op,
  output logic              busy
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  mcand_q;
  logic [WIDTH-1:0]  mplier_q;
  logic [WIDTH-1:0]  acc_q;
  logic [SH_W-1:0]   cnt_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [WIDTH-1:0]  wb_data_q;
  logic              out_valid_q;
  logic              illegal_q;
  logic              busy_q;

  logic              accept;
  logic [SH_W-1:0]   shamt;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_illegal;
  logic [WIDTH-1:0]  mul_sum;

  // HOLD passes ready through so a new op is taken on the same edge the result leaves
  assign in_ready   = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign wb_en      = out_valid_q && out_ready;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign illegal_op = illegal_q;
  assign busy       = busy_q;

  assign shamt   = opb[SH_W-1:0];
  assign mul_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Single-cycle result; MUL is handled by the iterative path
  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (op)
      OP_ADD:  alu_res = opa + opb;
      OP_SUB:  alu_res = opa - opb;
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_SLL:  alu_res = opa << shamt;
      OP_SRL:  alu_res = opa >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(opa) >>> shamt);
      OP_SLT:  alu_res = WIDTH'($signed(opa) < $signed(opb));
      OP_SLTU: alu_res = WIDTH'(opa < opb);
      OP_MUL:  alu_res = '0;
      default: alu_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_HOLD: begin
          if (accept) begin
            wb_addr_q <= rd_addr;
            if (op == OP_MUL) begin
              state_q     <= S_MUL;
              mcand_q     <= opa;
              mplier_q    <= opb;
              acc_q       <= '0;
              cnt_q       <= '0;
              out_valid_q <= 1'b0;
              illegal_q   <= 1'b0;
              busy_q      <= 1'b1;
            end else begin
              state_q     <= S_HOLD;
              wb_data_q   <= alu_res;
              illegal_q   <= alu_illegal;
              out_valid_q <= 1'b1;
            end
          end else if ((state_q == S_HOLD) && out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        S_MUL: begin
          acc_q    <= mul_sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + SH_W'(1);
          if (cnt_q == SH_W'(WIDTH - 1)) begin
            state_q     <= S_HOLD;
            wb_data_q   <= mul_sum;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed literal cases plus randomized
// traffic scored against a transaction-level arithmetic model.
module tb_alu_exec_stage;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic [AW-1:0] rd_addr;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic          wb_en;
  logic          illegal_op;
  logic          busy;
  logic          rnd_en = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic          ill;
  } res_t;

  res_t expq[$];

  alu_exec_stage #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .opa(opa), .opb(opb), .rd_addr(rd_addr),
    .out_valid(out_valid), .out_ready(out_ready), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_en(wb_en), .illegal_op(illegal_op), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: what each accepted op must write back, from plain arithmetic
  function automatic res_t model(logic [3:0] o, logic [W-1:0] a, logic [W-1:0] b,
                                 logic [AW-1:0] rd);
    res_t        r;
    logic [63:0] ext;
    int          sh;
    sh     = int'(b[4:0]);
    r.addr = rd;
    r.ill  = 1'b0;
    r.data = '0;
    case (o)
      4'd0:  r.data = a + b;
      4'd1:  r.data = a - b;
      4'd2:  r.data = a & b;
      4'd3:  r.data = a | b;
      4'd4:  r.data = a ^ b;
      4'd5:  r.data = a << sh;
      4'd6:  r.data = a >> sh;
      4'd7:  begin ext = {{32{a[31]}}, a} >> sh; r.data = ext[31:0]; end
      4'd8:  r.data = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd9:  r.data = (a < b) ? 32'd1 : 32'd0;
      4'd10: r.data = a * b;
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Present an op from the post-posedge phase and hold it until it is taken
  task automatic send(logic [3:0] o, logic [W-1:0] a, logic [W-1:0] b, logic [AW-1:0] rd);
    int n;
    n        = 0;
    op       = o;
    opa      = a;
    opb      = b;
    rd_addr  = rd;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 100) begin
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    chk1("result_timeout", out_valid, 1'b1);
  endtask

  task automatic run_op(string name, logic [3:0] o, logic [W-1:0] a, logic [W-1:0] b,
                        logic [AW-1:0] rd, logic [W-1:0] exp);
    send(o, a, b, rd);
    wait_valid();
    chk(name, wb_data, exp);
    @(posedge clk);
    #1;
  endtask

  // Compare process: every cycle, DUT output against the head of the expected queue
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        expq.delete();
      end else begin
        chk1("wb_en", wb_en, out_valid & out_ready);
        if (out_valid) begin
          if (expq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL spurious_result: got out_valid=1 expected no pending op at %0t", $time);
          end else begin
            chk("sb_data", wb_data, expq[0].data);
            chk("sb_addr", W'(wb_addr), W'(expq[0].addr));
            chk1("sb_illegal", illegal_op, expq[0].ill);
            if (out_ready) void'(expq.pop_front());
          end
        end
        if (in_valid && in_ready) expq.push_back(model(op, opa, opb, rd_addr));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [3:0]    ro;
    logic [W-1:0]  ra;
    logic [W-1:0]  rb;
    logic [AW-1:0] rr;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = '0;
    opa       = '0;
    opb       = '0;
    rd_addr   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_illegal", illegal_op, 1'b0);
    chk1("rst_wb_en", wb_en, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_addr", W'(wb_addr), 32'h0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    send(4'd0, 32'd5, 32'd7, 5'd3);
    @(negedge clk);
    chk1("add_out_valid", out_valid, 1'b1);
    chk("add_data", wb_data, 32'd12);
    chk("add_addr", W'(wb_addr), 32'd3);
    chk1("add_wb_en", wb_en, 1'b1);
    @(posedge clk);
    #1;

    run_op("sub", 4'd1, 32'd0, 32'd1, 5'd0, 32'hFFFF_FFFF);
    run_op("sra", 4'd7, 32'h8000_0000, 32'd4, 5'd1, 32'hF800_0000);
    run_op("srl", 4'd6, 32'h8000_0000, 32'd4, 5'd1, 32'h0800_0000);
    run_op("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 5'd2, 32'd1);
    run_op("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1, 5'd2, 32'd0);
    run_op("sll", 4'd5, 32'h0000_0003, 32'd31, 5'd2, 32'h8000_0000);

    send(4'd10, 32'h0000_FFFF, 32'h0001_0001, 5'd7);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk1("mul_busy", busy, 1'b1);
      chk1("mul_in_ready", in_ready, 1'b0);
      chk1("mul_early_valid", out_valid, 1'b0);
    end
    @(negedge clk);
    chk1("mul_done_valid", out_valid, 1'b1);
    chk1("mul_done_busy", busy, 1'b0);
    chk("mul_data", wb_data, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    run_op("mul_zero", 4'd10, 32'd0, 32'h1234_5678, 5'd8, 32'd0);

    // Backpressure with a new op waiting, then a back-to-back handoff
    out_ready = 1'b0;
    send(4'd2, 32'h0000_F0F0, 32'h0000_FF00, 5'd9);
    send_hold: begin
      op = 4'd3; opa = 32'h0000_00F0; opb = 32'h0000_000F; rd_addr = 5'd10; in_valid = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("bp_valid", out_valid, 1'b1);
      chk1("bp_wb_en", wb_en, 1'b0);
      chk1("bp_in_ready", in_ready, 1'b0);
      chk("bp_data", wb_data, 32'h0000_F000);
      chk("bp_addr", W'(wb_addr), 32'd9);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk1("b2b_wb_en", wb_en, 1'b1);
    chk1("b2b_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk1("b2b_valid", out_valid, 1'b1);
    chk("b2b_data", wb_data, 32'h0000_00FF);
    chk("b2b_addr", W'(wb_addr), 32'd10);
    @(posedge clk);
    #1;

    // Reset in the middle of a multiply drops it
    send(4'd10, 32'd3, 32'd5, 5'd11);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk1("abort_valid", out_valid, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    run_op("add_after_reset", 4'd0, 32'd100, 32'd23, 5'd4, 32'd123);

    send(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 5'd5);
    wait_valid();
    chk("illegal_data", wb_data, 32'd0);
    chk1("illegal_flag", illegal_op, 1'b1);
    @(posedge clk);
    #1;
    send(4'd4, 32'h0000_00FF, 32'h0000_00F0, 5'd6);
    wait_valid();
    chk("xor_data", wb_data, 32'h0000_000F);
    chk1("illegal_cleared", illegal_op, 1'b0);
    @(posedge clk);
    #1;

    // Random traffic with random backpressure, scored by the compare process
    rnd_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
      rr = AW'($urandom);
      send(ro, ra, rb, rr);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_en = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    n = 0;
    while (expq.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(expq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
